// File: rtl/ysyx_24070014_pkg.sv
`default_nettype none
// ============================================================================
// Module : ysyx_24070014_pkg
// Shared funct3, FSM state and byte-lane mask encodings for the LSU.
// Rev    : 1.0
// ============================================================================
package ysyx_24070014_pkg;

  localparam logic [2:0] c_f3_b  = 3'b000;
  localparam logic [2:0] c_f3_h  = 3'b001;
  localparam logic [2:0] c_f3_w  = 3'b010;
  localparam logic [2:0] c_f3_bu = 3'b100;
  localparam logic [2:0] c_f3_hu = 3'b101;

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_access = 2'd1;
  localparam logic [1:0] c_st_resp   = 2'd2;

  localparam logic [3:0] c_mask_b = 4'b0001;
  localparam logic [3:0] c_mask_h = 4'b0011;
  localparam logic [3:0] c_mask_w = 4'b1111;

  // Stores only have signed-width codes; unsigned variants are load-only.
  function automatic logic is_illegal(input logic wen, input logic [2:0] funct3);
    logic bad;
    bad = 1'b1;
    case (funct3)
      c_f3_b, c_f3_h, c_f3_w: bad = 1'b0;
      c_f3_bu, c_f3_hu:       bad = wen;
      default:                bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    return ((funct3[1:0] == 2'b01) && offset[0]) ||
           ((funct3[1:0] == 2'b10) && (offset != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_24070014_load_align.sv
`default_nettype none
// ============================================================================
// Module : ysyx_24070014_load_align
// Moves the addressed byte/halfword to bit 0 and sign- or zero-extends it.
// Rev    : 1.0
// ============================================================================
module ysyx_24070014_load_align
  import ysyx_24070014_pkg::*;
#(
  parameter int WORD_LEN = 32
) (
  input  logic [WORD_LEN-1:0] rdata,
  input  logic [1:0]          offset,
  input  logic [2:0]          funct3,
  output logic [WORD_LEN-1:0] data
);

  logic [WORD_LEN-1:0] w_shifted;

  assign w_shifted = rdata >> {offset, 3'b000};

  always_comb begin
    data = '0;
    case (funct3)
      c_f3_b:  data = {{(WORD_LEN-8){w_shifted[7]}}, w_shifted[7:0]};
      c_f3_h:  data = {{(WORD_LEN-16){w_shifted[15]}}, w_shifted[15:0]};
      c_f3_w:  data = w_shifted;
      c_f3_bu: data = {{(WORD_LEN-8){1'b0}}, w_shifted[7:0]};
      c_f3_hu: data = {{(WORD_LEN-16){1'b0}}, w_shifted[15:0]};
      default: data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_24070014_lsu.sv
`default_nettype none
// ============================================================================
// Module : ysyx_24070014_lsu
// Single-outstanding load/store unit: IDLE -> ACCESS (LATENCY cycles) -> RESP.
// Rev    : 1.0
// ============================================================================
module ysyx_24070014_lsu
  import ysyx_24070014_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_LEN   = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WORD_LEN-1:0]   req_wdata,
  input  logic                  req_wen,
  input  logic [2:0]            req_funct3,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WORD_LEN-1:0]   resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_LEN-1:0]   mem_wdata,
  output logic                  mem_wen,
  output logic [3:0]            mem_mask,
  input  logic [WORD_LEN-1:0]   mem_rdata
);

  localparam int              CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(LATENCY - 1);

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WORD_LEN-1:0]   r_wdata;
  logic                  r_wen;
  logic [2:0]            r_funct3;
  logic [WORD_LEN-1:0]   r_rdata;
  logic                  r_err;

  logic                  w_bad;
  logic                  w_access;
  logic                  w_last;
  logic [WORD_LEN-1:0]   w_load_data;

  assign w_bad    = is_illegal(req_wen, req_funct3) | is_misaligned(req_funct3, req_addr[1:0]);
  assign w_access = (r_state == c_st_access);
  assign w_last   = w_access && (r_cnt == '0);

  ysyx_24070014_load_align #(
    .WORD_LEN (WORD_LEN)
  ) u_load_align (
    .rdata  (mem_rdata),
    .offset (r_addr[1:0]),
    .funct3 (r_funct3),
    .data   (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= c_st_idle;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wen    <= 1'b0;
      r_funct3 <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (req_valid) begin
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_wen    <= req_wen;
            r_funct3 <= req_funct3;
            r_rdata  <= '0;
            if (w_bad) begin
              r_err   <= 1'b1;
              r_state <= c_st_resp;
            end else begin
              r_err   <= 1'b0;
              r_cnt   <= c_cnt_load;
              r_state <= c_st_access;
            end
          end
        end
        c_st_access: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_rdata <= r_wen ? '0 : w_load_data;
            r_state <= c_st_resp;
          end
        end
        c_st_resp: begin
          if (resp_ready) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  // Store data is replicated across lanes so the mask alone selects the bytes.
  always_comb begin
    mem_mask  = '0;
    mem_wdata = '0;
    if (w_access) begin
      case (r_funct3[1:0])
        2'b00: begin
          mem_mask  = c_mask_b << r_addr[1:0];
          mem_wdata = {(WORD_LEN/8){r_wdata[7:0]}};
        end
        2'b01: begin
          mem_mask  = c_mask_h << r_addr[1:0];
          mem_wdata = {(WORD_LEN/16){r_wdata[15:0]}};
        end
        default: begin
          mem_mask  = c_mask_w;
          mem_wdata = r_wdata;
        end
      endcase
    end
  end

  assign mem_addr   = w_access ? {r_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_wen    = w_last && r_wen && !reset;
  assign req_ready  = (r_state == c_st_idle);
  assign resp_valid = (r_state == c_st_resp);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24070014_lsu.sv
`default_nettype none
// ============================================================================
// Module : tb_ysyx_24070014_lsu
// Self-checking bench: directed vector table, random traffic vs a byte-array model.
// Rev    : 1.0
// ============================================================================
module tb_ysyx_24070014_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_valid, req_ready, req_wen, resp_valid, resp_ready, resp_err, mem_wen;
  logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  req_funct3;
  logic [3:0]  mem_mask;

  logic        reset3, req_valid3, req_ready3, req_wen3, resp_valid3, resp_ready3, resp_err3, mem_wen3;
  logic [31:0] req_addr3, req_wdata3, resp_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic [2:0]  req_funct3_3;
  logic [3:0]  mem_mask3;

  ysyx_24070014_lsu #(.ADDR_WIDTH(32), .WORD_LEN(32), .LATENCY(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wen(req_wen), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_mask(mem_mask),
    .mem_rdata(mem_rdata)
  );

  ysyx_24070014_lsu #(.ADDR_WIDTH(32), .WORD_LEN(32), .LATENCY(3)) dut3 (
    .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_addr(req_addr3), .req_wdata(req_wdata3), .req_wen(req_wen3), .req_funct3(req_funct3_3),
    .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_rdata(resp_rdata3), .resp_err(resp_err3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_wen(mem_wen3), .mem_mask(mem_mask3),
    .mem_rdata(mem_rdata3)
  );

  logic [31:0] mem1 [0:15];
  logic [31:0] mem3 [0:15];
  logic [7:0]  ref_b [0:63];
  int n_checks = 0;
  int n_err    = 0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 1) return 32'h8899_AABB;
    return 32'h1357_9BDF ^ (32'(i) * 32'h0101_0101);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem1[i] <= init_word(i);
    end else if (mem_wen) begin
      for (int b = 0; b < 4; b++)
        if (mem_mask[b]) mem1[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (reset3) begin
      for (int i = 0; i < 16; i++) mem3[i] <= init_word(i);
    end else if (mem_wen3) begin
      for (int b = 0; b < 4; b++)
        if (mem_mask3[b]) mem3[mem_addr3[5:2]][8*b +: 8] <= mem_wdata3[8*b +: 8];
    end
  end

  assign mem_rdata  = mem1[mem_addr[5:2]];
  assign mem_rdata3 = mem3[mem_addr3[5:2]];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] bytemask(input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  // Reference: memory as a flat byte array, accesses as byte sequences.
  task automatic model(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                       output int lat, output logic [3:0] mask);
    int size, off, base;
    logic legal;
    logic [31:0] v;
    off  = int'(addr[1:0]);
    base = int'(addr - 32'h8000_0000);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (wen) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else     legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
    err   = !legal || ((off % size) != 0);
    rdata = '0;
    lat   = 0;
    mask  = '0;
    if (!err) begin
      lat  = 1;
      mask = 4'(((1 << size) - 1) << off);
      if (wen) begin
        for (int i = 0; i < size; i++) ref_b[base + i] = wdata[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = ref_b[base + i];
        if (!f3[2] && size < 4 && v[8*size - 1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
        rdata = v;
      end
    end
  endtask

  task automatic txn(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                     output int lat, output int wens, output logic [3:0] mask,
                     output logic [31:0] maddr, output logic [31:0] mwd);
    @(negedge clk);
    req_valid  = 1'b1;
    req_wen    = wen;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; wens = 0; mask = '0; maddr = '0; mwd = '0;
    while (!resp_valid && lat < 20) begin
      if (mem_mask != 4'd0) begin
        mask = mem_mask; maddr = mem_addr; mwd = mem_wdata;
      end
      if (mem_wen) wens++;
      @(posedge clk); #1;
      lat++;
    end
    err   = resp_err;
    rdata = resp_rdata;
    @(posedge clk); #1;
  endtask

  task automatic exec(input string tag, input logic wen, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic exp_err, input logic [31:0] exp_rd,
                      input int exp_lat, input logic [3:0] exp_mask);
    logic g_err; logic [31:0] g_rd, g_maddr, g_mwd; int g_lat, g_wens; logic [3:0] g_mask;
    txn(wen, f3, addr, wdata, g_err, g_rd, g_lat, g_wens, g_mask, g_maddr, g_mwd);
    chk({tag, " err"},     32'(g_err), 32'(exp_err));
    chk({tag, " rdata"},   g_rd, exp_rd);
    chk({tag, " latency"}, 32'(g_lat), 32'(exp_lat));
    chk({tag, " wen_cnt"}, 32'(g_wens), (wen && !exp_err) ? 32'd1 : 32'd0);
    chk({tag, " mask"},    32'(g_mask), 32'(exp_mask));
    if (!exp_err) chk({tag, " mem_addr"}, g_maddr, addr & ~32'd3);
    if (wen && !exp_err)
      chk({tag, " lanes"}, g_mwd & bytemask(exp_mask),
          (wdata << {addr[1:0], 3'b000}) & bytemask(exp_mask));
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
  endtask

  typedef struct packed {
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs [0:18];
  logic        m_err;
  logic [31:0] m_rd;
  int          m_lat, n, w, bad;
  logic [3:0]  m_mask;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 3'b000, 32'h8000_0005, 32'h0,         1'b0, 32'hFFFF_FFAA};
    vecs[1]  = '{1'b0, 3'b101, 32'h8000_0006, 32'h0,         1'b0, 32'h0000_8899};
    vecs[2]  = '{1'b0, 3'b001, 32'h8000_0006, 32'h0,         1'b0, 32'hFFFF_8899};
    vecs[3]  = '{1'b0, 3'b010, 32'h8000_0004, 32'h0,         1'b0, 32'h8899_AABB};
    vecs[4]  = '{1'b0, 3'b100, 32'h8000_0004, 32'h0,         1'b0, 32'h0000_00BB};
    vecs[5]  = '{1'b0, 3'b010, 32'h8000_0002, 32'h0,         1'b1, 32'h0};
    vecs[6]  = '{1'b0, 3'b001, 32'h8000_0005, 32'h0,         1'b1, 32'h0};
    vecs[7]  = '{1'b0, 3'b011, 32'h8000_0004, 32'h0,         1'b1, 32'h0};
    vecs[8]  = '{1'b1, 3'b000, 32'h8000_0007, 32'h1234_5678, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 3'b010, 32'h8000_0004, 32'h0,         1'b0, 32'h7899_AABB};
    vecs[10] = '{1'b1, 3'b100, 32'h8000_0008, 32'h1111_1111, 1'b1, 32'h0};
    vecs[11] = '{1'b1, 3'b010, 32'h8000_000C, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 3'b000, 32'h8000_000F, 32'h0,         1'b0, 32'hFFFF_FFDE};
    vecs[13] = '{1'b0, 3'b101, 32'h8000_000E, 32'h0,         1'b0, 32'h0000_DEAD};
    vecs[14] = '{1'b1, 3'b001, 32'h8000_000A, 32'h0000_CAFE, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 3'b001, 32'h8000_000A, 32'h0,         1'b0, 32'hFFFF_CAFE};
    vecs[16] = '{1'b1, 3'b001, 32'h8000_0009, 32'h0000_5555, 1'b1, 32'h0};
    vecs[17] = '{1'b0, 3'b100, 32'h8000_000D, 32'h0,         1'b0, 32'h0000_00BE};
    vecs[18] = '{1'b0, 3'b111, 32'h8000_0004, 32'h0,         1'b1, 32'h0};

    for (int i = 0; i < 16; i++)
      for (int b = 0; b < 4; b++) ref_b[4*i + b] = init_word(i)[8*b +: 8];

    reset = 1'b1; reset3 = 1'b1;
    req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'b010; req_addr = 32'h8000_0000;
    req_wdata = 32'hFFFF_FFFF; resp_ready = 1'b1;
    req_valid3 = 1'b0; req_wen3 = 1'b0; req_funct3_3 = 3'b010; req_addr3 = 32'h8000_0000;
    req_wdata3 = 32'h0; resp_ready3 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; reset3 = 1'b0; req_valid = 1'b0;
    #1;
    chk("rst req_ready",  32'(req_ready), 32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_err",   32'(resp_err), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst mem_wen",    32'(mem_wen), 32'd0);
    chk("rst mem_mask",   32'(mem_mask), 32'd0);
    chk("rst mem_addr",   mem_addr, 32'd0);
    chk("rst mem_wdata",  mem_wdata, 32'd0);

    for (int i = 0; i < 19; i++) begin
      model(vecs[i].wen, vecs[i].f3, vecs[i].addr, vecs[i].wdata, m_err, m_rd, m_lat, m_mask);
      exec($sformatf("vec%0d", i), vecs[i].wen, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
           vecs[i].exp_err, vecs[i].exp_rd, m_lat, m_mask);
    end

    for (int i = 0; i < 250; i++) begin
      logic        r_wen;
      logic [2:0]  r_f3;
      logic [31:0] r_addr, r_wd;
      r_wen  = 1'($urandom_range(0, 1));
      r_f3   = 3'($urandom_range(0, 7));
      r_addr = 32'h8000_0000 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) r_addr[1:0] = 2'b00;
      r_wd   = $urandom;
      model(r_wen, r_f3, r_addr, r_wd, m_err, m_rd, m_lat, m_mask);
      exec("rnd", r_wen, r_f3, r_addr, r_wd, m_err, m_rd, m_lat, m_mask);
    end

    // Response back-pressure with a conflicting request waved at the busy LSU.
    model(1'b0, 3'b010, 32'h8000_0004, 32'h0, m_err, m_rd, m_lat, m_mask);
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0004;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    req_wen = 1'b1; req_addr = 32'h8000_0000; req_wdata = 32'hFFFF_FFFF;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hold latency", 32'(n), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("hold resp_valid", 32'(resp_valid), 32'd1);
      chk("hold resp_rdata", resp_rdata, m_rd);
      chk("hold req_ready",  32'(req_ready), 32'd0);
    end
    @(negedge clk);
    resp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    chk("hold release valid", 32'(resp_valid), 32'd0);
    chk("hold release ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("hold no access", 32'(mem_mask), 32'd0);
    model(1'b0, 3'b010, 32'h8000_0000, 32'h0, m_err, m_rd, m_lat, m_mask);
    exec("after hold", 1'b0, 3'b010, 32'h8000_0000, 32'h0, m_err, m_rd, m_lat, m_mask);

    // LATENCY=3: full store, then a store aborted by reset mid-access.
    @(negedge clk);
    req_valid3 = 1'b1; req_wen3 = 1'b1; req_funct3_3 = 3'b010;
    req_addr3 = 32'h8000_0010; req_wdata3 = 32'hA5A5_0F0F;
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    n = 0; w = 0;
    while (!resp_valid3 && n < 20) begin
      if (mem_wen3) w++;
      @(posedge clk); #1;
      n++;
    end
    chk("l3 latency", 32'(n), 32'd3);
    chk("l3 wen_cnt", 32'(w), 32'd1);
    @(posedge clk); #1;
    chk("l3 stored",    mem3[4], 32'hA5A5_0F0F);
    chk("l3 req_ready", 32'(req_ready3), 32'd1);

    @(negedge clk);
    req_valid3 = 1'b1; req_wen3 = 1'b1; req_funct3_3 = 3'b010;
    req_addr3 = 32'h8000_0014; req_wdata3 = 32'h1122_3344;
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    bad = 0;
    if (mem_wen3) bad++;
    @(posedge clk); #1;
    chk("abort mem_addr", mem_addr3, 32'h8000_0014);
    if (mem_wen3) bad++;
    @(negedge clk);
    reset3 = 1'b1;
    if (mem_wen3) bad++;
    @(posedge clk); #1;
    chk("abort req_ready",  32'(req_ready3), 32'd1);
    chk("abort resp_valid", 32'(resp_valid3), 32'd0);
    chk("abort mem_mask",   32'(mem_mask3), 32'd0);
    @(negedge clk);
    reset3 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (mem_wen3 || resp_valid3) bad++;
    end
    chk("abort no write/resp", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
